// File: rtl/line_clear_engine_pkg.sv
// Shared board constants, row-slice helper and FSM encodings for the line-clear engine.
`ifndef LINE_CLEAR_ENGINE_DEFS
`define LINE_CLEAR_ENGINE_DEFS
`define BOARD_COLS 10
`define BOARD_ROWS 20
`define CELL_LEN   3
`define ROW_LEN    (`BOARD_COLS*`CELL_LEN)
// Expects a ROW_LEN localparam in the caller's scope so it follows module parameters.
`define ROW_GET(board,y) board[(y)*ROW_LEN +: ROW_LEN]
`define LC_IDLE 2'd0
`define LC_SCAN 2'd1
`define LC_FILL 2'd2
`define LC_DONE 2'd3
`endif

package line_clear_engine_pkg;
  localparam int BOARD_COLS  = `BOARD_COLS;
  localparam int BOARD_ROWS  = `BOARD_ROWS;
  localparam int CELL_LEN    = `CELL_LEN;
  localparam int TOTAL_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = `LC_IDLE,
    ST_SCAN = `LC_SCAN,
    ST_FILL = `LC_FILL,
    ST_DONE = `LC_DONE
  } lc_state_e;
endpackage

// File: rtl/line_clear_engine_row_full_detect.sv
// Combinational full-row test: a row is full when no cell is empty (zero).
module row_full_detect #(
  parameter int COLS   = 10,
  parameter int CELL_W = 3
) (
  input  logic [COLS*CELL_W-1:0] row,
  output logic                   full
);
  always_comb begin
    full = 1'b1;
    for (int x = 0; x < COLS; x++) begin
      if (row[x*CELL_W +: CELL_W] == '0) full = 1'b0;
    end
  end
endmodule

// File: rtl/line_clear_engine.sv
// Row-clear engine: scans a committed board one row per cycle, drops full rows,
// compacts survivors downward and keeps a saturating running line total.
module line_clear_engine
  import line_clear_engine_pkg::*;
#(
  parameter int COLS    = BOARD_COLS,
  parameter int ROWS    = BOARD_ROWS,
  parameter int CELL_W  = CELL_LEN,
  parameter int TOTAL_W = TOTAL_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROWS*COLS*CELL_W-1:0]   board_in,
  input  logic                          clear_total,
  output logic                          busy,
  output logic                          done,
  output logic [ROWS*COLS*CELL_W-1:0]   board_out,
  output logic [ROWS-1:0]               rows_mask,
  output logic [$clog2(ROWS+1)-1:0]     lines_cleared,
  output logic [TOTAL_W-1:0]            total_lines
);
  localparam int ROW_LEN = COLS*CELL_W;
  localparam int SRC_W   = $clog2(ROWS);
  localparam int CNT_W   = $clog2(ROWS+1);
  localparam int SUM_W   = ((TOTAL_W > CNT_W) ? TOTAL_W : CNT_W) + 1;
  localparam logic [SRC_W-1:0] LAST_ROW  = SRC_W'(ROWS-1);
  localparam logic [SUM_W-1:0] TOTAL_MAX = SUM_W'({TOTAL_W{1'b1}});

  lc_state_e state, state_nxt;

  logic [ROWS-1:0][ROW_LEN-1:0] work;
  logic [ROWS-1:0][ROW_LEN-1:0] out_q;
  logic [SRC_W-1:0]             src;
  logic [CNT_W-1:0]             dst;
  logic [CNT_W-1:0]             count;
  logic [ROWS-1:0]              mask;
  logic                         row_full;
  logic [SUM_W-1:0]             sum;

  row_full_detect #(.COLS(COLS), .CELL_W(CELL_W)) u_full (
    .row  (work[src]),
    .full (row_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_SCAN;
      ST_SCAN: begin
        busy = 1'b1;
        if (src == LAST_ROW) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work          <= '0;
      out_q         <= '0;
      src           <= '0;
      dst           <= '0;
      count         <= '0;
      mask          <= '0;
      rows_mask     <= '0;
      lines_cleared <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          for (int y = 0; y < ROWS; y++) work[y] <= `ROW_GET(board_in, y);
          src   <= '0;
          dst   <= '0;
          count <= '0;
          mask  <= '0;
        end
        ST_SCAN: begin
          // dst never passes src, so moving a survivor down cannot clobber an unscanned row.
          if (row_full) begin
            mask[src] <= 1'b1;
            count     <= count + CNT_W'(1);
          end else begin
            work[dst] <= work[src];
            dst       <= dst + CNT_W'(1);
          end
          src <= (src == LAST_ROW) ? '0 : src + SRC_W'(1);
        end
        ST_FILL: begin
          for (int y = 0; y < ROWS; y++)
            out_q[y] <= (CNT_W'(y) >= dst) ? '0 : work[y];
          rows_mask     <= mask;
          lines_cleared <= count;
        end
        default: ;
      endcase
    end
  end

  // Widened so a large count cannot wrap before the saturation compare.
  assign sum = SUM_W'(total_lines) + SUM_W'(count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 total_lines <= '0;
    else if (clear_total)     total_lines <= '0;
    else if (state == ST_FILL)
      total_lines <= (sum > TOTAL_MAX) ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
  end

  assign board_out = out_q;
endmodule

// File: tb/tb_line_clear_engine.sv
// Self-checking bench: behavioural compaction model plus hand-computed expectations.
module tb_line_clear_engine;
  localparam int COLS = 10, ROWS = 20, CELL_W = 3, TOTAL_W = 16, SAT_W = 2;
  localparam int BW = ROWS*COLS*CELL_W;
  localparam int RL = COLS*CELL_W;
  localparam int CW = $clog2(ROWS+1);

  typedef struct packed {
    logic [BW-1:0]   b;
    logic [ROWS-1:0] m;
    logic [7:0]      c;
  } res_t;

  logic clk = 1'b0, rst, start, clear_total;
  logic [BW-1:0] board_in;
  logic busy, done, s_busy, s_done;
  logic [BW-1:0] board_out, s_board_out;
  logic [ROWS-1:0] rows_mask, s_rows_mask;
  logic [CW-1:0] lines_cleared, s_lines_cleared;
  logic [TOTAL_W-1:0] total_lines;
  logic [SAT_W-1:0] s_total;

  int n_cmp = 0, n_bad = 0;

  line_clear_engine #(.COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .TOTAL_W(TOTAL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .board_in(board_in), .clear_total(clear_total),
    .busy(busy), .done(done), .board_out(board_out), .rows_mask(rows_mask),
    .lines_cleared(lines_cleared), .total_lines(total_lines));

  line_clear_engine #(.COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .TOTAL_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .board_in(board_in), .clear_total(clear_total),
    .busy(s_busy), .done(s_done), .board_out(s_board_out), .rows_mask(s_rows_mask),
    .lines_cleared(s_lines_cleared), .total_lines(s_total));

  always #5 clk = ~clk;

  // Survivors keep their order and are stacked from row 0 upward.
  function automatic res_t compact(input logic [BW-1:0] bin);
    res_t r;
    int d;
    logic full;
    r = '0;
    d = 0;
    for (int y = 0; y < ROWS; y++) begin
      full = 1'b1;
      for (int x = 0; x < COLS; x++)
        if (bin[(y*COLS+x)*CELL_W +: CELL_W] == '0) full = 1'b0;
      if (full) begin
        r.m[y] = 1'b1;
        r.c    = r.c + 8'd1;
      end else begin
        r.b[d*RL +: RL] = bin[y*RL +: RL];
        d++;
      end
    end
    return r;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [BW-1:0] put(input logic [BW-1:0] bd, input int x, input int y,
                                        input logic [CELL_W-1:0] v);
    logic [BW-1:0] r;
    r = bd;
    r[(y*COLS+x)*CELL_W +: CELL_W] = v;
    return r;
  endfunction

  // Model: ph counts cycles since the accepted start (0 = idle).
  res_t c_res, p_res;
  int ph = 0, m_tot = 0, m_tot_s = 0;
  logic [BW-1:0] m_out = '0;
  logic [ROWS-1:0] m_mask = '0;
  int m_cnt = 0;

  always_comb c_res = compact(board_in);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph <= 0; m_out <= '0; m_mask <= '0; m_cnt <= 0; m_tot <= 0; m_tot_s <= 0; p_res <= '0;
    end else begin
      if (ph == 0) begin
        if (start) begin ph <= 1; p_res <= c_res; end
      end else if (ph == ROWS+2) ph <= 0;
      else ph <= ph + 1;
      if (ph == ROWS+1) begin
        m_out <= p_res.b; m_mask <= p_res.m; m_cnt <= int'(p_res.c);
      end
      if (clear_total) begin
        m_tot <= 0; m_tot_s <= 0;
      end else if (ph == ROWS+1) begin
        m_tot   <= sat(m_tot + int'(p_res.c), TOTAL_W);
        m_tot_s <= sat(m_tot_s + int'(p_res.c), SAT_W);
      end
    end
  end

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [BW-1:0] bd, input int extra_at, input int clr_at);
    int lat;
    bit fin;
    board_in = bd; start = 1'b1; lat = 0; fin = 0;
    while (!fin) begin
      @(negedge clk);
      lat++;
      start       = (lat == extra_at);
      clear_total = (lat == clr_at);
      if (done) fin = 1;
      else if (lat > 60) begin
        chk("done_timeout", BW'(lat), BW'(ROWS+2));
        fin = 1;
      end
    end
    if (lat <= 60) chk("latency", BW'(lat), BW'(ROWS+2));
    @(negedge clk);
    start = 1'b0; clear_total = 1'b0;
  endtask

  logic [BW-1:0] b, e;
  int dcnt;

  initial begin
    rst = 1'b0; start = 1'b0; clear_total = 1'b0; board_in = '0;
    fork
      forever begin
        @(negedge clk);
        chk("busy",       BW'(busy),          BW'(ph >= 1 && ph <= ROWS+1));
        chk("done",       BW'(done),          BW'(ph == ROWS+2));
        chk("board_out",  board_out,          m_out);
        chk("rows_mask",  BW'(rows_mask),     BW'(m_mask));
        chk("lines",      BW'(lines_cleared), BW'(m_cnt));
        chk("total",      BW'(total_lines),   BW'(m_tot));
        chk("total_sat",  BW'(s_total),       BW'(m_tot_s));
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_board", board_out, '0);
    chk("rst_busy", BW'(busy), '0);
    chk("rst_total", BW'(total_lines), '0);
    rst = 1'b1;
    @(negedge clk);

    // Empty board
    run_op('0, 0, 0);
    chk("t1_board", board_out, '0);
    chk("t1_mask", BW'(rows_mask), '0);
    chk("t1_total", BW'(total_lines), '0);

    // Full bottom row, lone brick above drops into row 0
    b = '0;
    for (int x = 0; x < COLS; x++) b = put(b, x, 0, 3'd3);
    b = put(b, 4, 1, 3'd5);
    run_op(b, 0, 0);
    e = put('0, 4, 0, 3'd5);
    chk("t2_board", board_out, e);
    chk("t2_mask", BW'(rows_mask), BW'(20'h00001));
    chk("t2_lines", BW'(lines_cleared), BW'(1));
    chk("t2_total", BW'(total_lines), BW'(1));

    // Non-contiguous full rows
    b = '0;
    for (int x = 0; x < COLS; x++) begin b = put(b, x, 0, 3'd6); b = put(b, x, 2, 3'd1); end
    b = put(b, 0, 1, 3'd2);
    b = put(b, 9, 3, 3'd7);
    run_op(b, 0, 0);
    e = put(put('0, 0, 0, 3'd2), 9, 1, 3'd7);
    chk("t3_board", board_out, e);
    chk("t3_mask", BW'(rows_mask), BW'(20'h00005));
    chk("t3_lines", BW'(lines_cleared), BW'(2));

    // Extra start in cycle 5 is dropped; no second done
    run_op(b, 5, 0);
    dcnt = 0;
    repeat (30) begin @(negedge clk); if (done) dcnt++; end
    chk("t4_extra_done", BW'(dcnt), '0);
    chk("t4_total", BW'(total_lines), BW'(5));

    // Saturation on the narrow instance
    clear_total = 1'b1; @(negedge clk); clear_total = 1'b0;
    repeat (3) run_op(b, 0, 0);
    chk("t5_sat", BW'(s_total), BW'(3));
    chk("t5_total", BW'(total_lines), BW'(6));
    clear_total = 1'b1; @(negedge clk); clear_total = 1'b0;
    chk("t5_clear", BW'(total_lines), '0);
    // clear_total during FILL beats the accumulation
    run_op(b, 0, ROWS+1);
    chk("t5_clr_fill", BW'(total_lines), '0);

    // Async reset mid-scan
    board_in = b; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_busy", BW'(busy), '0);
    chk("t6_board", board_out, '0);
    chk("t6_mask", BW'(rows_mask), '0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    run_op(b, 0, 0);
    chk("t6_after_mask", BW'(rows_mask), BW'(20'h00005));
    chk("t6_after_total", BW'(total_lines), BW'(2));

    // Every row full
    b = '0;
    for (int y = 0; y < ROWS; y++) for (int x = 0; x < COLS; x++) b = put(b, x, y, 3'd1);
    run_op(b, 0, ROWS+2);
    chk("t7_board", board_out, '0);
    chk("t7_mask", BW'(rows_mask), BW'(20'hFFFFF));
    chk("t7_lines", BW'(lines_cleared), BW'(20));

    // Randomised operations
    for (int k = 0; k < 40; k++) begin
      b = '0;
      for (int y = 0; y < ROWS; y++) begin
        bit mk_full;
        mk_full = ($urandom % 3) == 0;
        for (int x = 0; x < COLS; x++)
          b = put(b, x, y, (!mk_full && ($urandom % 4) == 0) ? 3'd0 : 3'($urandom_range(1, 7)));
      end
      run_op(b, (($urandom % 3) == 0) ? int'($urandom_range(1, ROWS+2)) : 0,
                (($urandom % 8) == 0) ? int'($urandom_range(1, ROWS+2)) : 0);
      repeat ($urandom % 3) @(negedge clk);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
